// File: rtl/hazard_interlock.sv
// rtl/hazard_interlock.sv - register scoreboard, RAW/WAW interlock and branch flush sequencer
module hazard_interlock #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            instr_ID,
    input  logic                   instr_valid_ID,
    input  logic [4:0]             rs1_raddr_ID,
    input  logic [4:0]             rs2_raddr_ID,
    input  logic [4:0]             rd_waddr_ID,
    input  logic [1:0]             rs1_ID_fwd,
    input  logic [1:0]             rs2_ID_fwd,
    input  logic                   wb_valid_RB,
    input  logic [4:0]             rd_waddr_RB,
    input  logic                   branch_taken_EX,
    output logic                   stall_IF,
    output logic                   stall_ID,
    output logic                   bubble_EX,
    output logic                   flush_ID,
    output logic [31:0]            pending,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Flush cycles after the redirect cycle itself, minus the one FLUSH state visit that ends at fcnt==0
    localparam logic [2:0] FLUSH_LOAD = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             fcnt_q, fcnt_d;
    logic [31:0][1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic writes_rd, uses_rs1, uses_rs2;
    logic hazard, issue;
    logic unused_instr;

    assign unused_instr = ^instr_ID[31:7];

    always_comb begin
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (instr_ID[6:0])
            OP_R:      begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LOAD:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_IMM:    begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_JAL:    writes_rd = 1'b1;
            OP_JALR:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_LUI:    writes_rd = 1'b1;
            OP_AUIPC:  writes_rd = 1'b1;
            default:   ;
        endcase
    end

    // WAW term keeps a 2-bit counter from wrapping past 3
    always_comb begin
        hazard = instr_valid_ID && (
            (uses_rs1 && (rs1_raddr_ID != 5'd0) && (cnt_q[rs1_raddr_ID] != 2'd0) && (rs1_ID_fwd == 2'd0)) ||
            (uses_rs2 && (rs2_raddr_ID != 5'd0) && (cnt_q[rs2_raddr_ID] != 2'd0) && (rs2_ID_fwd == 2'd0)) ||
            (writes_rd && (rd_waddr_ID != 5'd0) && (cnt_q[rd_waddr_ID] == 2'd3)));
    end

    assign flush_ID  = branch_taken_EX || (state_q == FLUSH);
    assign stall_ID  = hazard && !flush_ID;
    assign stall_IF  = stall_ID;
    assign bubble_EX = stall_ID || flush_ID;
    assign issue     = instr_valid_ID && !stall_ID && !flush_ID;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pending[r] = (cnt_q[r] != 2'd0);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < 32; r++) begin
            logic inc, dec;
            inc = issue && writes_rd && (rd_waddr_ID == 5'(r));
            dec = wb_valid_RB && (rd_waddr_RB == 5'(r));
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec && !inc && (cnt_q[r] != 2'd0)) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
        cnt_d[0] = 2'd0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_ID && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (branch_taken_EX) begin
            state_d = FLUSH_MULTI ? FLUSH : RUN;
            fcnt_d  = FLUSH_LOAD;
        end else begin
            case (state_q)
                RUN:     if (hazard) state_d = STALL;
                STALL:   if (!hazard) state_d = RUN;
                FLUSH: begin
                    if (fcnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_interlock.sv
// tb/tb_hazard_interlock.sv - scoreboard bench for hazard_interlock
module tb_hazard_interlock;

    localparam int FC = 2;
    localparam int SW = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr_ID;
    logic          instr_valid_ID;
    logic [4:0]    rs1_raddr_ID, rs2_raddr_ID, rd_waddr_ID;
    logic [1:0]    rs1_ID_fwd, rs2_ID_fwd;
    logic          wb_valid_RB;
    logic [4:0]    rd_waddr_RB;
    logic          branch_taken_EX;
    logic          stall_IF, stall_ID, bubble_EX, flush_ID;
    logic [31:0]   pending;
    logic [SW-1:0] stall_cnt;

    hazard_interlock #(.FLUSH_CYCLES(FC), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_ID(instr_ID), .instr_valid_ID(instr_valid_ID),
        .rs1_raddr_ID(rs1_raddr_ID), .rs2_raddr_ID(rs2_raddr_ID), .rd_waddr_ID(rd_waddr_ID),
        .rs1_ID_fwd(rs1_ID_fwd), .rs2_ID_fwd(rs2_ID_fwd), .wb_valid_RB(wb_valid_RB),
        .rd_waddr_RB(rd_waddr_RB), .branch_taken_EX(branch_taken_EX), .stall_IF(stall_IF),
        .stall_ID(stall_ID), .bubble_EX(bubble_EX), .flush_ID(flush_ID), .pending(pending),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        flush;
        logic [31:0] pend;
        logic [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int m_cnt[32];
    int m_flush_left;
    int m_scnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_flush_left = 0;
        m_scnt = 0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        for (int r = 0; r < 32; r++) p[r] = (m_cnt[r] != 0);
        return p;
    endfunction

    task automatic tick(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [1:0] f1, input logic [1:0] f2,
                        input logic wv, input logic [4:0] wrd, input logic br);
        logic w, u1, u2, haz, fl, st, iss;
        exp_t e, got;
        @(negedge clk);
        instr_ID        = {7'd0, r2, r1, 3'd0, rd, op};
        instr_valid_ID  = v;
        rs1_raddr_ID    = r1;
        rs2_raddr_ID    = r2;
        rd_waddr_ID     = rd;
        rs1_ID_fwd      = f1;
        rs2_ID_fwd      = f2;
        wb_valid_RB     = wv;
        rd_waddr_RB     = wrd;
        branch_taken_EX = br;
        #1;
        w   = (op == OP_R) || (op == OP_IMM);
        u1  = (op == OP_R) || (op == OP_IMM);
        u2  = (op == OP_R);
        haz = v && ((u1 && r1 != 0 && m_cnt[r1] != 0 && f1 == 0) ||
                    (u2 && r2 != 0 && m_cnt[r2] != 0 && f2 == 0) ||
                    (w && rd != 0 && m_cnt[rd] == 3));
        fl  = br || (m_flush_left > 0);
        st  = haz && !fl;
        iss = v && !st && !fl;
        e.stall  = st;
        e.bubble = st || fl;
        e.flush  = fl;
        e.pend   = model_pending();
        e.scnt   = 32'(m_scnt);
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        check("stall_ID",  32'(stall_ID),  32'(got.stall));
        check("stall_IF",  32'(stall_IF),  32'(got.stall));
        check("bubble_EX", 32'(bubble_EX), 32'(got.bubble));
        check("flush_ID",  32'(flush_ID),  32'(got.flush));
        check("pending",   pending,        got.pend);
        check("stall_cnt", 32'(stall_cnt), got.scnt);
        @(posedge clk);
        if (iss && w && rd != 0) m_cnt[rd]++;
        if (wv && wrd != 0 && m_cnt[wrd] > 0) m_cnt[wrd]--;
        if (st && m_scnt < (1 << SW) - 1) m_scnt++;
        if (br) m_flush_left = FC - 1;
        else if (m_flush_left > 0) m_flush_left--;
    endtask

    task automatic idle(input logic wv, input logic [4:0] wrd);
        tick(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, wv, wrd, 1'b0);
    endtask

    task automatic after_edge();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_ID = '0; instr_valid_ID = 1'b0;
        rs1_raddr_ID = '0; rs2_raddr_ID = '0; rd_waddr_ID = '0;
        rs1_ID_fwd = '0; rs2_ID_fwd = '0;
        wb_valid_RB = 1'b0; rd_waddr_RB = '0; branch_taken_EX = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b0, 5'd0);

        // RAW on x5 without bypass: 3 held cycles plus the writeback cycle
        tick(1'b1, OP_R, 5'd0, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        repeat (3) tick(1'b1, OP_R, 5'd5, 5'd0, 5'd6, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_R, 5'd5, 5'd0, 5'd6, 2'd0, 2'd0, 1'b1, 5'd5, 1'b0);
        tick(1'b1, OP_R, 5'd5, 5'd0, 5'd6, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        check("stall_cnt_raw", 32'(stall_cnt), 32'd4);
        idle(1'b1, 5'd6);

        // Same dependency covered by a bypass
        tick(1'b1, OP_R, 5'd0, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_R, 5'd5, 5'd0, 5'd6, 2'd1, 2'd0, 1'b0, 5'd0, 1'b0);
        idle(1'b1, 5'd5);
        idle(1'b1, 5'd6);
        after_edge();
        check("pending_clean", pending, 32'd0);
        check("stall_cnt_fwd", 32'(stall_cnt), 32'd4);

        // Same-cycle issue and writeback of x7, then an rd=x0 issue
        tick(1'b1, OP_IMM, 5'd0, 5'd0, 5'd7, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_IMM, 5'd0, 5'd0, 5'd7, 2'd0, 2'd0, 1'b1, 5'd7, 1'b0);
        after_edge();
        check("pending_x7_same", pending, 32'h0000_0080);
        tick(1'b1, OP_R, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        after_edge();
        check("pending_x0_issue", pending, 32'h0000_0080);
        idle(1'b1, 5'd7);

        // Fourth in-flight write to x9 waits for one writeback
        repeat (3) tick(1'b1, OP_IMM, 5'd0, 5'd0, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) tick(1'b1, OP_IMM, 5'd0, 5'd0, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_IMM, 5'd0, 5'd0, 5'd9, 2'd0, 2'd0, 1'b1, 5'd9, 1'b0);
        tick(1'b1, OP_IMM, 5'd0, 5'd0, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        repeat (3) idle(1'b1, 5'd9);
        // Decrement of an idle counter is ignored
        idle(1'b1, 5'd9);
        after_edge();
        check("pending_x9_drained", pending, 32'd0);

        // Redirect while a RAW hazard is held, then a second redirect mid-flush
        tick(1'b1, OP_IMM, 5'd0, 5'd0, 5'd10, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);

        // Saturate the stall counter
        repeat (20) tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        check("stall_cnt_sat", 32'(stall_cnt), 32'd15);

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        #2;
        check("stall_before_rst", 32'(stall_ID), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_stall_ID",  32'(stall_ID),  32'd0);
        check("rst_bubble_EX", 32'(bubble_EX), 32'd0);
        check("rst_flush_ID",  32'(flush_ID),  32'd0);
        check("rst_pending",   pending,        32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b0, 5'd0);
        tick(1'b1, OP_R, 5'd10, 5'd0, 5'd11, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
